// File: rtl/ring_phase_tracker.sv
// One-hot ring phase decoder and sequence checker; outputs registered, 1-cycle latency, no backpressure.
// Define RING_TRACK_ERRCNT_EN to add the saturating ERR_CNT lock-loss counter.
module ring_phase_tracker #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 3,
    localparam int W       = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] RING,
    input  logic         ADV,
    output logic [W-1:0] INDEX,
    output logic         VALID,
    output logic         LOCKED,
    output logic         ERR,
    output logic [1:0]   ERR_CODE
`ifdef RING_TRACK_ERRCNT_EN
    ,
    output logic [7:0]   ERR_CNT
`endif
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_ZERO  = 2'b01;
    localparam logic [1:0] CODE_MULTI = 2'b10;
    localparam logic [1:0] CODE_POS   = 2'b11;

    state_t         state, state_nxt;
    logic [3:0]     good, good_nxt;
    logic [W-1:0]   prev_idx;
    logic           prev_adv;
    logic           err_nxt;
    logic [1:0]     code_nxt;

    logic           onehot;
    logic           zero;
    logic [W-1:0]   pos;
    logic [W-1:0]   exp_idx;
    logic           hit;

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (RING[i]) pos = W'(i);
        end
    end

    assign onehot  = $onehot(RING);
    assign zero    = ~|RING;
    // Wrap is explicit so non-power-of-two rings work too.
    assign exp_idx = !prev_adv ? prev_idx :
                     (prev_idx == W'(N - 1)) ? '0 : prev_idx + 1'b1;
    assign hit     = onehot && (pos == exp_idx);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_nxt   = 1'b0;
        code_nxt  = ERR_CODE;
        case (state)
            S_SEARCH: begin
                if (onehot) begin
                    state_nxt = S_TRACK;
                    good_nxt  = '0;
                end
            end
            S_TRACK: begin
                if (!onehot) begin
                    state_nxt = S_SEARCH;
                    good_nxt  = '0;
                end else if (hit) begin
                    if (good + 4'd1 == 4'(LOCK_CNT)) begin
                        state_nxt = S_LOCK;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good + 4'd1;
                    end
                end else begin
                    good_nxt = '0;
                end
            end
            S_LOCK: begin
                if (!hit) begin
                    err_nxt   = 1'b1;
                    code_nxt  = zero ? CODE_ZERO : (!onehot ? CODE_MULTI : CODE_POS);
                    state_nxt = onehot ? S_TRACK : S_SEARCH;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_SEARCH;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_SEARCH;
            good     <= '0;
            prev_idx <= '0;
            prev_adv <= 1'b0;
            INDEX    <= '0;
            VALID    <= 1'b0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else begin
            state    <= state_nxt;
            good     <= good_nxt;
            VALID    <= onehot;
            LOCKED   <= (state_nxt == S_LOCK);
            ERR      <= err_nxt;
            ERR_CODE <= code_nxt;
            if (onehot) begin
                INDEX    <= pos;
                prev_idx <= pos;
                prev_adv <= ADV;
            end
        end
    end

`ifdef RING_TRACK_ERRCNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ERR_CNT <= 8'd0;
        end else if (err_nxt && ERR_CNT != 8'hFF) begin
            ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_phase_tracker.sv
// Directed scoreboard bench for ring_phase_tracker (N=8, LOCK_CNT=3).
module tb_ring_phase_tracker;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] RING;
    logic       ADV;
    logic [2:0] INDEX;
    logic       VALID;
    logic       LOCKED;
    logic       ERR;
    logic [1:0] ERR_CODE;
`ifdef RING_TRACK_ERRCNT_EN
    logic [7:0] ERR_CNT;
`endif

    ring_phase_tracker #(.N(8), .LOCK_CNT(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RING     (RING),
        .ADV      (ADV),
        .INDEX    (INDEX),
        .VALID    (VALID),
        .LOCKED   (LOCKED),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
`ifdef RING_TRACK_ERRCNT_EN
        ,
        .ERR_CNT  (ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] idx;
        logic       vld;
        logic       lck;
        logic       err;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one sample, queue its expected outputs, then pop and compare after the edge.
    task automatic step(input logic r, input logic [7:0] ring, input logic adv,
                        input logic [2:0] idx, input logic v, input logic l,
                        input logic e, input logic [1:0] c);
        exp_t ex;
        exp_t got;
        RESET = r;
        RING  = ring;
        ADV   = adv;
        ex.idx = idx; ex.vld = v; ex.lck = l; ex.err = e; ex.code = c;
        q.push_back(ex);
        @(posedge CLK);
        #1;
        got = q.pop_front();
        chk("index",    {5'd0, INDEX},    {5'd0, got.idx});
        chk("valid",    {7'd0, VALID},    {7'd0, got.vld});
        chk("locked",   {7'd0, LOCKED},   {7'd0, got.lck});
        chk("err",      {7'd0, ERR},      {7'd0, got.err});
        chk("err_code", {6'd0, ERR_CODE}, {6'd0, got.code});
    endtask

    initial begin
        RESET = 1'b1;
        RING  = 8'h00;
        ADV   = 1'b0;
        @(posedge CLK);
        #1;
        step(1, 8'h00, 0, 0, 0, 0, 0, 2'd0);
        step(1, 8'h01, 1, 0, 0, 0, 0, 2'd0);

        // Acquire: lock from the 4th output
        step(0, 8'h01, 1, 0, 1, 0, 0, 2'd0);
        step(0, 8'h02, 1, 1, 1, 0, 0, 2'd0);
        step(0, 8'h04, 1, 2, 1, 0, 0, 2'd0);
        step(0, 8'h08, 1, 3, 1, 1, 0, 2'd0);
        step(0, 8'h10, 1, 4, 1, 1, 0, 2'd0);
        step(0, 8'h20, 1, 5, 1, 1, 0, 2'd0);
        step(0, 8'h40, 1, 6, 1, 1, 0, 2'd0);
        step(0, 8'h80, 1, 7, 1, 1, 0, 2'd0);
        // Wrap 7 -> 0
        step(0, 8'h01, 1, 0, 1, 1, 0, 2'd0);
        step(0, 8'h02, 1, 1, 1, 1, 0, 2'd0);
        step(0, 8'h04, 1, 2, 1, 1, 0, 2'd0);
        // Skip 2 -> 4
        step(0, 8'h10, 1, 4, 1, 0, 1, 2'd3);
        step(0, 8'h20, 1, 5, 1, 0, 0, 2'd3);
        step(0, 8'h40, 1, 6, 1, 0, 0, 2'd3);
        step(0, 8'h80, 1, 7, 1, 1, 0, 2'd3);
        step(0, 8'h01, 1, 0, 1, 1, 0, 2'd3);
        // Zero-hot then multi-hot
        step(0, 8'h00, 1, 0, 0, 0, 1, 2'd1);
        step(0, 8'h18, 1, 0, 0, 0, 0, 2'd1);
        // Relock, then hold without ADV
        step(0, 8'h01, 1, 0, 1, 0, 0, 2'd1);
        step(0, 8'h02, 1, 1, 1, 0, 0, 2'd1);
        step(0, 8'h04, 1, 2, 1, 0, 0, 2'd1);
        step(0, 8'h08, 0, 3, 1, 1, 0, 2'd1);
        step(0, 8'h08, 0, 3, 1, 1, 0, 2'd1);
        step(0, 8'h08, 0, 3, 1, 1, 0, 2'd1);
        step(0, 8'h10, 0, 4, 1, 0, 1, 2'd3);
        // Relock, then multi-hot while locked
        step(0, 8'h10, 1, 4, 1, 0, 0, 2'd3);
        step(0, 8'h20, 1, 5, 1, 0, 0, 2'd3);
        step(0, 8'h40, 1, 6, 1, 1, 0, 2'd3);
        step(0, 8'h03, 1, 6, 0, 0, 1, 2'd2);
        // Wrong position during TRACK restarts silently
        step(0, 8'h01, 1, 0, 1, 0, 0, 2'd2);
        step(0, 8'h08, 1, 3, 1, 0, 0, 2'd2);
        step(0, 8'h10, 1, 4, 1, 0, 0, 2'd2);
        step(0, 8'h20, 1, 5, 1, 0, 0, 2'd2);
        step(0, 8'h40, 1, 6, 1, 1, 0, 2'd2);
        // Reset while locked
        step(1, 8'h80, 1, 0, 0, 0, 0, 2'd0);

`ifdef RING_TRACK_ERRCNT_EN
        begin
            int pos;
            int errs;
            logic [7:0] r;
            pos  = 0;
            errs = 0;
            r = 8'h01;
            step(0, r, 1, 0, 1, 0, 0, 2'd0);
            for (int i = 0; i < 300; i++) begin
                for (int k = 1; k <= 3; k++) begin
                    pos = pos + 1;
                    r = 8'h01 << (pos % 8);
                    step(0, r, 1, 3'(pos % 8), 1, (k == 3), 0, (i == 0) ? 2'd0 : 2'd3);
                end
                pos = pos + 2;
                r = 8'h01 << (pos % 8);
                step(0, r, 1, 3'(pos % 8), 1, 0, 1, 2'd3);
                errs = errs + 1;
                if (i == 9) chk("err_cnt_10", ERR_CNT, 8'd10);
            end
            chk("err_cnt_sat", ERR_CNT, (errs > 255) ? 8'd255 : 8'(errs));
            for (int k = 1; k <= 3; k++) begin
                pos = pos + 1;
                r = 8'h01 << (pos % 8);
                step(0, r, 1, 3'(pos % 8), 1, (k == 3), 0, 2'd3);
            end
            chk("err_cnt_hold", ERR_CNT, 8'd255);
            step(1, r, 1, 0, 0, 0, 0, 2'd0);
            chk("err_cnt_rst", ERR_CNT, 8'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
